fifo_fwft: RTL and testbench

- Synchronous first-word-fall-through sample FIFO.
- Sits on both sides of every streaming stage in the FM datapath: the responder for a stage's out_wr_en/out_full/out_din and in_rd_en/in_empty/in_dout ports.
- Consumers assert rd_en combinationally from !empty and sample dout in the same cycle. The head word must therefore be valid on dout whenever empty=0, with no read latency.

---
 rtl/fifo_fwft_pkg.sv | 8 +
 rtl/fifo_fwft.sv | 76 +++++++
 tb/tb_fifo_fwft.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_fwft_pkg.sv
// Shared streaming definitions for the FM datapath sample FIFOs.
package fifo_fwft_pkg;

    localparam int unsigned SAMPLE_WIDTH = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through sample FIFO: head word is presented on dout whenever empty is low,
// so consumers may pop combinationally from !empty with zero read latency.
module fifo_fwft
    import fifo_fwft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_accept;
    logic                rd_accept;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage is deliberately left uncleared by reset; only the pointers define contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (wr_accept) begin
                mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
            end
        end
    end

endmodule

// File: tb/tb_fifo_fwft.sv
// Scoreboard bench for fifo_fwft: stimulus queues expected read data, a monitor pops and compares.
module tb_fifo_fwft;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks;
    int errors;
    logic [DW-1:0] exp_q [$];

    fifo_fwft #(
        .DATA_WIDTH(DW),
        .DEPTH     (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .din      (din),
        .full     (full),
        .rd_en    (rd_en),
        .dout     (dout),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then return inputs to idle.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic rst);
        wr_en = w;
        din   = d;
        rd_en = r;
        reset = rst;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
    endtask

    // Monitor: an accepted read is rd_en with a non-empty FIFO; dout must be the oldest word.
    initial begin
        forever begin
            @(negedge clock);
            if (rd_en && !empty && !reset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", {16'h0, dout}, 32'hFFFF_FFFF);
                end else begin
                    check("read_data", {16'h0, dout}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        reset  = 1'b1;

        // Reset state
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("rst_empty", {31'h0, empty}, 32'd1);
        check("rst_full", {31'h0, full}, 32'd0);
        check("rst_count", {27'h0, count}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        check("rst_underflow", {31'h0, underflow}, 32'd0);

        // 1: four writes then four reads
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(DW'(i));
            step(1'b1, DW'(i), 1'b0, 1'b0);
        end
        check("t1_count", {27'h0, count}, 32'd4);
        check("t1_empty", {31'h0, empty}, 32'd0);
        check("t1_head", {16'h0, dout}, 32'h0001);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t1_drained", {31'h0, empty}, 32'd1);

        // 2: fill to full, dropped write, drain in order
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(16'h1000 + DW'(i));
            step(1'b1, 16'h1000 + DW'(i), 1'b0, 1'b0);
        end
        check("t2_full", {31'h0, full}, 32'd1);
        check("t2_count16", {27'h0, count}, 32'd16);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("t2_overflow", {31'h0, overflow}, 32'd1);
        check("t2_count_hold", {27'h0, count}, 32'd16);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t2_overflow_pulse", {31'h0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t2_drained", {31'h0, empty}, 32'd1);

        // 3: full with simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(16'h2000 + DW'(i));
            step(1'b1, 16'h2000 + DW'(i), 1'b0, 1'b0);
        end
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        check("t3_overflow", {31'h0, overflow}, 32'd1);
        check("t3_count", {27'h0, count}, 32'd15);
        check("t3_full", {31'h0, full}, 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t3_drained", {31'h0, empty}, 32'd1);

        // 4: empty with simultaneous read and write
        exp_q.push_back(16'h0042);
        step(1'b1, 16'h0042, 1'b1, 1'b0);
        check("t4_underflow", {31'h0, underflow}, 32'd1);
        check("t4_empty", {31'h0, empty}, 32'd0);
        check("t4_dout", {16'h0, dout}, 32'h0042);
        check("t4_count", {27'h0, count}, 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t4_underflow_pulse", {31'h0, underflow}, 32'd0);
        check("t4_drained", {31'h0, empty}, 32'd1);

        // 5: prefill 3, then 40 cycles of concurrent write/read across pointer wrap
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h3000 + DW'(i));
            step(1'b1, 16'h3000 + DW'(i), 1'b0, 1'b0);
        end
        for (int i = 3; i < 43; i++) begin
            exp_q.push_back(16'h3000 + DW'(i));
            step(1'b1, 16'h3000 + DW'(i), 1'b1, 1'b0);
            check("t5_count", {27'h0, count}, 32'd3);
            check("t5_flags", {30'h0, overflow, underflow}, 32'd0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t5_drained", {31'h0, empty}, 32'd1);

        // 6: reset with 5 words stored while writing; stored words are discarded
        for (int i = 0; i < 5; i++) step(1'b1, 16'h4000 + DW'(i), 1'b0, 1'b0);
        check("t6_count5", {27'h0, count}, 32'd5);
        step(1'b1, 16'h5555, 1'b0, 1'b1);
        check("t6_empty", {31'h0, empty}, 32'd1);
        check("t6_count", {27'h0, count}, 32'd0);
        check("t6_full", {31'h0, full}, 32'd0);
        exp_q.push_back(16'h7FFF);
        step(1'b1, 16'h7FFF, 1'b0, 1'b0);
        check("t6_dout", {16'h0, dout}, 32'h7FFF);
        check("t6_not_empty", {31'h0, empty}, 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("t6_drained", {31'h0, empty}, 32'd1);

        check("scoreboard_left", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
